// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registers requests onto the inputs of a combinational ALU, holds them for
// SETTLE cycles, then captures the ALU result into a small in-order output FIFO.
// Optional feature macro: ALU_FLAGS_EN (adds per-entry zero/negative flags on the output).
module alu_issue_stage #(
    parameter int unsigned W      = 32,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned DEPTH  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_c_in,
    input  logic [2:0]   in_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_c_in,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result
`ifdef ALU_FLAGS_EN
    ,
    output logic         out_zero,
    output logic         out_neg
`endif
);

    localparam int unsigned CntW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CntFW = $clog2(DEPTH + 1);

    localparam logic [CntW-1:0]  CntLast = CntW'(SETTLE - 1);
    localparam logic [CntFW-1:0] FifoFull = CntFW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StExec, StStall} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CntFW-1:0] count_q, count_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [W-1:0]     mem_q [DEPTH];

`ifdef ALU_FLAGS_EN
    logic             zero_q [DEPTH];
    logic             neg_q  [DEPTH];
`endif

    logic final_cycle;
    logic can_write;
    logic push;
    logic pop;
    logic accept;

    // Handshake decode: the stage can only release its operands when the FIFO has room,
    // counting a pop on the same edge as room.
    always_comb begin
        out_valid   = (count_q != '0);
        pop         = out_valid && out_ready;
        can_write   = (count_q != FifoFull) || pop;
        final_cycle = ((state_q == StExec) && (cnt_q == CntLast)) || (state_q == StStall);
        push        = final_cycle && can_write;
        in_ready    = !rst && ((state_q == StIdle) || push);
        accept      = in_valid && in_ready;
    end

    // Next-state and settle-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StExec;
                    cnt_d   = '0;
                end
            end
            StExec, StStall: begin
                if (accept) begin
                    // Result leaves this edge and a new request takes its place.
                    state_d = StExec;
                    cnt_d   = '0;
                end else if (push) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (!final_cycle) begin
                    cnt_d = cnt_q + CntW'(1);
                end else begin
                    state_d = StStall;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // FIFO occupancy update.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntFW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntFW'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Operand registers driving the ALU; only an accepted request changes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_c_in <= 1'b0;
            alu_op   <= 3'b000;
        end else if (accept) begin
            alu_a    <= in_a;
            alu_b    <= in_b;
            alu_c_in <= in_c_in;
            alu_op   <= in_op;
        end
    end

    // FIFO storage; cleared on reset so no stale result can be presented later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
`ifdef ALU_FLAGS_EN
                zero_q[i] <= 1'b0;
                neg_q[i]  <= 1'b0;
`endif
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= alu_result;
`ifdef ALU_FLAGS_EN
            zero_q[wr_ptr_q] <= (alu_result == '0);
            neg_q[wr_ptr_q]  <= alu_result[W-1];
`endif
        end
    end

    // Head of FIFO is presented straight from storage.
    always_comb begin
        out_result = mem_q[rd_ptr_q];
`ifdef ALU_FLAGS_EN
        out_zero   = zero_q[rd_ptr_q];
        out_neg    = neg_q[rd_ptr_q];
`endif
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a stub adder ALU (a + b + c_in).
// Main instance uses SETTLE=1, DEPTH=2; a second instance checks SETTLE=3 timing.
module tb_alu_issue_stage;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, in_c_in;
    logic [W-1:0] in_a, in_b;
    logic [2:0]   in_op;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic         alu_c_in;
    logic [2:0]   alu_op;
    logic         out_valid, out_ready;
    logic [W-1:0] out_result;
`ifdef ALU_FLAGS_EN
    logic         out_zero, out_neg;
`endif

    logic         s3_in_valid, s3_in_ready, s3_in_c_in;
    logic [W-1:0] s3_in_a, s3_in_b;
    logic [2:0]   s3_in_op;
    logic [W-1:0] s3_alu_a, s3_alu_b, s3_alu_result;
    logic         s3_alu_c_in;
    logic [2:0]   s3_alu_op;
    logic         s3_out_valid, s3_out_ready;
    logic [W-1:0] s3_out_result;
`ifdef ALU_FLAGS_EN
    logic         s3_out_zero, s3_out_neg;
`endif

    // Stub ALUs: plain adders.
    assign alu_result    = alu_a + alu_b + W'(alu_c_in);
    assign s3_alu_result = s3_alu_a + s3_alu_b + W'(s3_alu_c_in);

    alu_issue_stage #(.W(W), .SETTLE(1), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c_in    (in_c_in),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c_in   (alu_c_in),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef ALU_FLAGS_EN
        ,
        .out_zero   (out_zero),
        .out_neg    (out_neg)
`endif
    );

    alu_issue_stage #(.W(W), .SETTLE(3), .DEPTH(2)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (s3_in_valid),
        .in_ready   (s3_in_ready),
        .in_a       (s3_in_a),
        .in_b       (s3_in_b),
        .in_c_in    (s3_in_c_in),
        .in_op      (s3_in_op),
        .alu_a      (s3_alu_a),
        .alu_b      (s3_alu_b),
        .alu_c_in   (s3_alu_c_in),
        .alu_op     (s3_alu_op),
        .alu_result (s3_alu_result),
        .out_valid  (s3_out_valid),
        .out_ready  (s3_out_ready),
        .out_result (s3_out_result)
`ifdef ALU_FLAGS_EN
        ,
        .out_zero   (s3_out_zero),
        .out_neg    (s3_out_neg)
`endif
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         neg;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_head;
    exp_t        sb_new;
    logic [W-1:0] sb_sum;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_pops   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: push on accept, pop/compare on delivery; both sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_pops++;
                if (sb_q.size() == 0) begin
                    check("pop_without_request", 64'(out_valid), 64'(0));
                end else begin
                    sb_head = sb_q.pop_front();
                    check("sb_result", 64'(out_result), 64'(sb_head.res));
`ifdef ALU_FLAGS_EN
                    check("sb_zero", 64'(out_zero), 64'(sb_head.zero));
                    check("sb_neg", 64'(out_neg), 64'(sb_head.neg));
`endif
                end
            end
            if (in_valid && in_ready) begin
                sb_sum      = in_a + in_b + W'(in_c_in);
                sb_new.res  = sb_sum;
                sb_new.zero = (sb_sum == '0);
                sb_new.neg  = sb_sum[W-1];
                sb_q.push_back(sb_new);
            end
        end
    end

    // Present one request and wait (bounded) for it to be accepted.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [2:0] op, output int waits);
        logic took;
        took     = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_c_in  = c;
        in_op    = op;
        for (int i = 0; i < 50 && !took; i++) begin
            @(negedge clk);
            took = in_ready;
            waits++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("accepted_in_time", 64'(took), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    int          w;
    int unsigned pops_before;
    logic        took4;

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        in_c_in      = 1'b0;
        in_op        = 3'b000;
        out_ready    = 1'b1;
        s3_in_valid  = 1'b0;
        s3_in_a      = '0;
        s3_in_b      = '0;
        s3_in_c_in   = 1'b0;
        s3_in_op     = 3'b000;
        s3_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_alu_a", 64'(alu_a), 64'(0));
        check("rst_alu_op", 64'(alu_op), 64'(0));
        check("rst_s3_in_ready", 64'(s3_in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Single op, SETTLE=1: 5+7+1 = 13
        issue(32'd5, 32'd7, 1'b1, 3'b010, w);
        check("single_alu_op", 64'(alu_op), 64'(3'b010));
        check("single_alu_a", 64'(alu_a), 64'(5));
        check("single_out_valid_early", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        check("single_out_valid", 64'(out_valid), 64'(1));
        check("single_out_result", 64'(out_result), 64'(13));
        @(posedge clk);
        #1;

        // Back-to-back, full throughput
        for (int i = 1; i <= 4; i++) begin
            issue(W'(i), W'(i), 1'b0, 3'b000, w);
            check("b2b_one_cycle_accept", 64'(w), 64'(1));
        end
        repeat (4) @(posedge clk);
        #1;
        check("b2b_drained", 64'(sb_q.size()), 64'(0));

        // Backpressure: FIFO fills, third op stalls, fourth waits
        out_ready   = 1'b0;
        pops_before = n_pops;
        issue(32'd10, 32'd1, 1'b0, 3'b001, w);
        issue(32'd20, 32'd2, 1'b0, 3'b001, w);
        issue(32'd30, 32'd3, 1'b0, 3'b001, w);
        in_valid = 1'b1;
        in_a     = 32'd40;
        in_b     = 32'd4;
        in_c_in  = 1'b1;
        in_op    = 3'b001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_alu_a_held", 64'(alu_a), 64'(30));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        took4 = 1'b0;
        for (int k = 0; k < 20 && !took4; k++) begin
            @(negedge clk);
            took4 = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("stall_fourth_accepted", 64'(took4), 64'(1));
        repeat (8) @(posedge clk);
        #1;
        check("stall_all_delivered", 64'(n_pops - pops_before), 64'(4));
        check("stall_drained", 64'(sb_q.size()), 64'(0));

        // SETTLE=3 instance: 10+20
        s3_in_valid = 1'b1;
        s3_in_a     = 32'd10;
        s3_in_b     = 32'd20;
        @(negedge clk);
        check("s3_ready_idle", 64'(s3_in_ready), 64'(1));
        @(posedge clk);
        #1 s3_in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("s3_ready_low", 64'(s3_in_ready), 64'(0));
            check("s3_not_yet_valid", 64'(s3_out_valid), 64'(0));
        end
        @(negedge clk);
        check("s3_ready_final", 64'(s3_in_ready), 64'(1));
        check("s3_valid_before_write", 64'(s3_out_valid), 64'(0));
        @(negedge clk);
        check("s3_out_valid", 64'(s3_out_valid), 64'(1));
        check("s3_out_result", 64'(s3_out_result), 64'(30));
        check("s3_alu_a", 64'(s3_alu_a), 64'(10));
        @(posedge clk);
        #1 s3_out_ready = 1'b1;
        @(posedge clk);
        #1 s3_out_ready = 1'b0;
        @(negedge clk);
        check("s3_popped", 64'(s3_out_valid), 64'(0));

        // Reset while stalled with a full FIFO
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(32'd50, 32'd1, 1'b0, 3'b000, w);
        issue(32'd60, 32'd1, 1'b0, 3'b000, w);
        issue(32'd70, 32'd1, 1'b0, 3'b000, w);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_rst_stalled", 64'(in_ready), 64'(0));
        check("pre_rst_full", 64'(out_valid), 64'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_forces_ready_low", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", 64'(out_valid), 64'(0));
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        check("post_rst_alu_a", 64'(alu_a), 64'(0));
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_no_stale", 64'(out_valid), 64'(0));
        end
        @(posedge clk);
        #1;

        // Flag corner cases (results checked in every build)
        issue(32'd1, 32'hFFFF_FFFF, 1'b0, 3'b000, w);
        issue(32'h7FFF_FFFF, 32'd1, 1'b0, 3'b000, w);
        check("wrap_result", 64'(out_result), 64'(0));
`ifdef ALU_FLAGS_EN
        check("wrap_zero", 64'(out_zero), 64'(1));
        check("wrap_neg", 64'(out_neg), 64'(0));
`endif
        @(posedge clk);
        #1;
        check("ovf_result", 64'(out_result), 64'(32'h8000_0000));
`ifdef ALU_FLAGS_EN
        check("ovf_zero", 64'(out_zero), 64'(0));
        check("ovf_neg", 64'(out_neg), 64'(1));
`endif
        repeat (3) @(posedge clk);
        #1;
        check("final_drained", 64'(sb_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
